// File: rtl/psg_pkg.sv
// Shared PSG definitions used by the tone generator and its observers.
package psg_pkg;

   localparam int PSG_PERIOD_BITS = 12;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } tone_meter_state_t;

endpackage

// File: rtl/sync_edge.sv
// Synchronises an asynchronous line into the clk domain and flags every
// transition of the synchronised level with a one-cycle pulse.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift chain plus one extra flop holding the previous synchronised level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level      = sync_q[SYNC_STAGES-1];
   assign edge_pulse = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/tone_period_meter.sv
// Measures the half-period of a square wave in enable ticks and reports it
// as the equivalent tone period register value.
module tone_period_meter
   import psg_pkg::*;
#(
   parameter int PERIOD_BITS = PSG_PERIOD_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   tone_in,
   output logic [PERIOD_BITS-1:0] period_out,
   output logic                   valid,
   output logic                   locked,
   output logic                   timeout
);

   tone_meter_state_t      state;
   logic [PERIOD_BITS-1:0] half_cnt;
   logic [PERIOD_BITS-1:0] enable_step;
   logic [PERIOD_BITS-1:0] measurement;
   logic                   have_prev;
   logic                   tone_edge;
   logic                   overflow;
   logic                   level_unused;

   // Only the edge pulse matters here; the level is used by other observers
   sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (tone_in),
      .level     (level_unused),
      .edge_pulse(tone_edge)
   );

   assign enable_step = {{(PERIOD_BITS-1){1'b0}}, enable};
   assign measurement = half_cnt + enable_step;
   assign overflow    = enable && (half_cnt == {PERIOD_BITS{1'b1}});

   // Overflow wins over a coincident edge so the counter can never wrap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         half_cnt   <= '0;
         have_prev  <= 1'b0;
         period_out <= '0;
         valid      <= 1'b0;
         locked     <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (tone_edge) begin
                  state     <= MEASURE;
                  half_cnt  <= '0;
                  have_prev <= 1'b0;
               end
            end
            MEASURE: begin
               if (overflow) begin
                  timeout   <= 1'b1;
                  locked    <= 1'b0;
                  have_prev <= 1'b0;
                  half_cnt  <= '0;
                  state     <= IDLE;
               end else if (tone_edge) begin
                  period_out <= measurement;
                  valid      <= 1'b1;
                  half_cnt   <= '0;
                  timeout    <= 1'b0;
                  locked     <= have_prev && (measurement == period_out);
                  have_prev  <= 1'b1;
               end else begin
                  half_cnt <= measurement;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tone_period_meter.sv
// Self-checking bench: a behavioural AY tone generator drives tone_in and
// queues the expected measurement for every half-wave it produces.
module tb_tone_period_meter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        tone_in;
   logic [11:0] period_out;
   logic        valid;
   logic        locked;
   logic        timeout;

   typedef struct {
      int period;
      int locked;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int failures = 0;

   bit gen_run;
   int gen_period;
   int gen_ticks;
   int en_div;
   int en_phase;
   int cycles_since;
   int toggle_count;
   bit m_armed;
   bit m_have_prev;
   int m_last;

   tone_period_meter #(
      .PERIOD_BITS(12),
      .SYNC_STAGES(2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .tone_in   (tone_in),
      .period_out(period_out),
      .valid     (valid),
      .locked    (locked),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Expected result of a half-wave: the first edge after reset/timeout only arms
   function automatic void modelEdge(input int ticks);
      exp_t e;
      if (!m_armed) begin
         m_armed     = 1'b1;
         m_have_prev = 1'b0;
      end else begin
         e.period = ticks;
         e.locked = (m_have_prev && (ticks == m_last)) ? 1 : 0;
         exp_q.push_back(e);
         m_last      = ticks;
         m_have_prev = 1'b1;
      end
   endfunction

   // One clock: check outputs after the edge, then advance the generator and enable
   task automatic applyStimulus();
      exp_t e;
      int   limit;
      @(posedge clk);
      #1;
      cycles_since++;
      if (valid) begin
         if (exp_q.size() == 0) begin
            checkOutput("spurious_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("period", period_out, e.period);
            checkOutput("locked", locked, e.locked);
            checkOutput("timeout_on_valid", timeout, 32'd0);
         end
      end
      if (gen_run && enable) begin
         gen_ticks++;
         limit = (gen_period == 0) ? 1 : gen_period;
         if (gen_ticks >= limit) begin
            tone_in = ~tone_in;
            toggle_count++;
            cycles_since = 0;
            modelEdge(gen_ticks);
            gen_ticks = 0;
         end
      end
      en_phase = (en_phase + 1) % en_div;
      enable   = (en_phase == 0);
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic waitToggles(input int n, input int bound);
      int start;
      int i;
      start = toggle_count;
      i = 0;
      while ((toggle_count - start) < n && i < bound) begin
         applyStimulus();
         i++;
      end
      if ((toggle_count - start) < n) checkOutput("toggle_wait", toggle_count - start, n);
   endtask

   task automatic drain();
      gen_run = 1'b0;
      runCycles(6);
      checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
   endtask

   // Asynchronous reset mid-cycle; outputs must clear before the next clock edge
   task automatic applyReset(input int div, input int period);
      #3;
      reset_n = 1'b0;
      #1;
      checkOutput("rst_period", period_out, 32'd0);
      checkOutput("rst_valid", valid, 32'd0);
      checkOutput("rst_locked", locked, 32'd0);
      checkOutput("rst_timeout", timeout, 32'd0);
      gen_run     = 1'b0;
      tone_in     = 1'b0;
      exp_q.delete();
      m_armed     = 1'b0;
      m_have_prev = 1'b0;
      m_last      = 0;
      gen_ticks   = 0;
      gen_period  = period;
      en_div      = div;
      en_phase    = 0;
      enable      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      gen_run = 1'b1;
   endtask

   initial begin
      reset_n      = 1'b0;
      enable       = 1'b0;
      tone_in      = 1'b0;
      gen_run      = 1'b0;
      gen_period   = 4;
      gen_ticks    = 0;
      en_div       = 1;
      en_phase     = 0;
      cycles_since = 0;
      toggle_count = 0;
      m_armed      = 1'b0;
      m_have_prev  = 1'b0;
      m_last       = 0;
      #1;
      checkOutput("init_period", period_out, 32'd0);
      checkOutput("init_valid", valid, 32'd0);
      checkOutput("init_locked", locked, 32'd0);
      checkOutput("init_timeout", timeout, 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] period 4, continuous enable");
      applyReset(1, 4);
      waitToggles(6, 100);
      drain();

      $display("[TB] period 0 then period 1");
      applyReset(1, 0);
      waitToggles(8, 50);
      gen_period = 1;
      waitToggles(8, 50);
      drain();

      $display("[TB] period 100, enable 1-in-8");
      applyReset(8, 100);
      waitToggles(4, 4000);
      drain();

      $display("[TB] period 8 changed to 3 after a toggle");
      applyReset(1, 8);
      waitToggles(3, 100);
      gen_period = 3;
      waitToggles(3, 50);
      drain();

      $display("[TB] timeout on a stalled input, then recovery at period 5");
      applyReset(1, 4);
      waitToggles(4, 100);
      gen_run = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         applyStimulus();
         if (timeout) break;
      end
      checkOutput("timeout_seen", timeout, 32'd1);
      checkOutput("timeout_latency", cycles_since, 32'd4099);
      checkOutput("locked_after_timeout", locked, 32'd0);
      checkOutput("period_held", period_out, m_last);
      checkOutput("timeout_queue", exp_q.size(), 32'd0);
      m_armed     = 1'b0;
      m_have_prev = 1'b0;
      gen_period  = 5;
      gen_ticks   = 0;
      gen_run     = 1'b1;
      waitToggles(1, 20);
      runCycles(3);
      checkOutput("timeout_sticky", timeout, 32'd1);
      waitToggles(3, 50);
      drain();

      $display("[TB] reset mid-window at period 6");
      applyReset(1, 6);
      waitToggles(4, 100);
      runCycles(2);
      checkOutput("pre_reset_period", period_out, 32'd6);
      applyReset(1, 6);
      waitToggles(3, 100);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tone_period_meter.md
# tone_period_meter

Measures the half-period of an incoming AY-style square wave, counted in clock-enable ticks, and reports the equivalent 12-bit tone period value. It is the inverse of the tone generator: the generator turns a period register into a toggling flip-flop, and this block turns a toggling line back into a period value. It sits beside the PSG channels for self-test and loopback checking, and for analysing external tone inputs.

## Interface
- PERIOD_BITS, 12: width of the measured period and of the internal counter.
- SYNC_STAGES, 2: synchronizer depth on `tone_in`. Minimum 2.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset. This is the only clock domain.
- enable  in  1  count-enable strobe. Same strobe that drives the tone generator (PSG clock/8 tick).
- tone_in  in  1  square wave to measure. May be asynchronous to `clk`.
- period_out  out  PERIOD_BITS  last valid measurement. Reset value 0.
- valid  out  1  one-cycle pulse when `period_out` updates. Reset value 0.
- locked  out  1  high while the last two consecutive measurements were equal. Reset value 0.
- timeout  out  1  sticky; set when a half-wave exceeds the counter range. Reset value 0.

## Operation
- `tone_in` passes through SYNC_STAGES flops, all reset to 0, then a previous-value flop (reset 0). An edge is any difference between the last sync stage and the previous-value flop; both rising and falling edges count.
- `half_cnt` (PERIOD_BITS) counts `enable`-high cycles since the last edge.
- A measurement window is the span after the previous edge cycle (exclusive) up to and including the current edge cycle. The measurement is `half_cnt + enable` for the current cycle.
- This matches the generator exactly. Period N gives N; period 0 and period 1 both give 1.
- State machine, encoded in 1 bit:
  - IDLE (reset state): no reference edge yet. An edge moves to MEASURE and clears `half_cnt`. No `valid` is produced and the have_prev flag is cleared.
  - MEASURE, edge and no overflow: `period_out <= measurement`, `valid <= 1`, `half_cnt <= 0`, `timeout <= 0`.
    - `locked <= have_prev && (measurement == period_out)`.
    - `have_prev <= 1`.
    - Stay in MEASURE.
  - MEASURE, no edge: `half_cnt += enable`.
- Overflow occurs when `half_cnt == 2^PERIOD_BITS-1` and `enable` = 1, whether or not an edge is present in that cycle. On overflow:
  - `timeout <= 1`, `locked <= 0`, have_prev `<= 0`.
  - `period_out` holds its value, and there is no `valid`.
  - Go to IDLE.
- The maximum legal measurement is 2^PERIOD_BITS-1. The counter never wraps.
- When `enable` = 0, counting stops but edges are still detected. An edge in such a cycle yields `measurement = half_cnt`.
- A measurement of 0 is possible only if two edges arrive with no enable between them (glitch). It is reported as 0 with `valid`, and `locked` follows the normal rule.
- Asserting `reset_n` low at any point, including mid-measurement, immediately clears every flop and output. After release, the first edge only arms the block.

## Timing
- Latency from `tone_in` transition to `valid`: the input is captured at clk edge k, and `valid` and `period_out` are registered at clk edge k+SYNC_STAGES. For the default depth that is 2 clocks after capture.
- `valid` is high for exactly one cycle per accepted measurement. The back-to-back minimum is every cycle, when enable is continuous and the period is 1.
- `locked` and `timeout` update in the same cycle as `valid`, or in the same cycle as the overflow event.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Shared package `psg_pkg`:
  - `PSG_PERIOD_BITS` = 12
  - `tone_meter_state_t` enum {IDLE, MEASURE}
- Sub-module `sync_edge`:
  - Parameter SYNC_STAGES; async active-low reset.
  - Outputs: synchronized level and a one-cycle `edge` pulse.
  - Reusable for the noise and envelope observers.
- Top level holds the counter, the FSM and the output registers.

## Test plan
- Continuous enable, `tone_ay` with period=4 looped into `tone_in`: the first edge arms only. Afterwards `valid` pulses every 4 clks with `period_out`=4, and `locked`=1 from the second `valid` onward.
- Generator period=0, then period=1: `period_out`=1 in both cases, `valid` every clk, `locked`=1.
- Enable 1-in-8, period=100: `period_out`=100, `valid` spaced 800 clks, `timeout`=0.
- Period 8 → 3, written on the cycle after a generator toggle: the next measurement is 3 with `locked`=0. The following measurement is 3 with `locked`=1.
- `tone_in` held constant after arming, continuous enable: `timeout`=1 and `locked`=0 on the 4096th enable tick, and `period_out` is unchanged. Resuming a period=5 wave gives arm, then `valid` with 5 and `timeout` cleared.
- `reset_n` pulsed low mid-window: all outputs read 0 at once, asynchronously. After release, the first edge produces no `valid` and the second edge gives the correct period.
